// File: rtl/qtable_update_engine_if.sv
// qtable_update_engine_if: sample handshake, Q-table read/write port and update results
//   master: engine side (drives o_*, receives i_*)
//   slave : environment/table side (drives i_*, receives o_*)
interface qtable_update_engine_if #(
  parameter int STATE_W    = 6,
  parameter int ACTION_W   = 2,
  parameter int DATA_WIDTH = 8
);
  localparam int AW = STATE_W + ACTION_W;
  logic                  i_valid;
  logic                  o_ready;
  logic [STATE_W-1:0]    i_state;
  logic [ACTION_W-1:0]   i_action;
  logic [DATA_WIDTH-1:0] i_reward;
  logic [STATE_W-1:0]    i_next_state;
  logic                  i_terminal;
  logic                  o_rd_en;
  logic [AW-1:0]         o_rd_addr;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  o_wr_en;
  logic [AW-1:0]         o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  o_done;
  logic [ACTION_W-1:0]   o_best_action;
  logic [DATA_WIDTH-1:0] o_max_q;
  modport master (
    input  i_valid, i_state, i_action, i_reward, i_next_state, i_terminal, i_rd_data,
    output o_ready, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_done,
           o_best_action, o_max_q
  );
  modport slave (
    output i_valid, i_state, i_action, i_reward, i_next_state, i_terminal, i_rd_data,
    input  o_ready, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_done,
           o_best_action, o_max_q
  );
endinterface

// File: rtl/qtable_update_engine.sv
// qtable_update_engine: one Bellman update per accepted sample against a Q-table BRAM port
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : sample handshake in, table read/write port out, last update's argmax/max Q out
module qtable_update_engine #(
  parameter int STATE_W     = 6,
  parameter int ACTION_W    = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int ALPHA_SHIFT = 1,
  parameter int GAMMA_SHIFT = 3
) (
  input logic                   i_clk,
  input logic                   i_rst,
  qtable_update_engine_if.master bus
);
  localparam int NUM_ACT = 2 ** ACTION_W;
  localparam int AW      = STATE_W + ACTION_W;
  localparam int CW      = ACTION_W + 1;
  localparam int W       = DATA_WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(NUM_ACT);
  localparam logic [CW-1:0] PEN  = CW'(NUM_ACT - 1);
  localparam logic signed [W-1:0] QMAX = W'((1 << DATA_WIDTH) - 1);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, CALC, WRITE} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_nx;
  logic [STATE_W-1:0]    s_q, s_d, ns_q, ns_d;
  logic [ACTION_W-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic                  term_q, term_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [CW-1:0]         rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [ACTION_W-1:0]   run_best_q, run_best_d;
  logic [DATA_WIDTH-1:0] qsa_q, qsa_d;
  logic                  ready_q, ready_d;
  logic                  rd_en_q, rd_en_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic [ACTION_W-1:0]   best_q, best_d;
  logic [DATA_WIDTH-1:0] max_out_q, max_out_d;
  logic signed [W-1:0]   r_s, qsa_s, mq, target, delta, q_new;
  logic [DATA_WIDTH-1:0] q_clamped;
  always_comb begin
    r_s       = $signed(W'(r_q));
    qsa_s     = $signed(W'(qsa_q));
    mq        = term_q ? '0 : $signed(W'(run_max_q));
    target    = r_s + mq - (mq >>> GAMMA_SHIFT);
    delta     = target - qsa_s;
    q_new     = qsa_s + (delta >>> ALPHA_SHIFT);
    q_clamped = q_new[W-1] ? '0 : (q_new > QMAX) ? {DATA_WIDTH{1'b1}} : q_new[DATA_WIDTH-1:0];
  end
  always_comb begin
    state_d    = state_q;
    cnt_nx     = cnt_q + CW'(1);
    cnt_d      = cnt_q;
    s_d        = s_q;
    a_d        = a_q;
    r_d        = r_q;
    ns_d       = ns_q;
    term_d     = term_q;
    rd_vld_d   = rd_en_q;
    rd_idx_d   = cnt_q;
    run_max_d  = run_max_q;
    run_best_d = run_best_q;
    qsa_d      = qsa_q;
    ready_d    = ready_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    best_d     = best_q;
    max_out_d  = max_out_q;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        state_d    = READ;
        cnt_d      = '0;
        s_d        = bus.i_state;
        a_d        = bus.i_action;
        r_d        = bus.i_reward;
        ns_d       = bus.i_next_state;
        term_d     = bus.i_terminal;
        ready_d    = 1'b0;
        rd_en_d    = 1'b1;
        rd_addr_d  = {bus.i_next_state, {ACTION_W{1'b0}}};
        run_max_d  = '0;
        run_best_d = '0;
      end
      READ: begin
        cnt_d     = cnt_nx;
        state_d   = (cnt_q == LAST) ? DRAIN : READ;
        rd_en_d   = cnt_q != LAST;
        rd_addr_d = (cnt_q < PEN) ? {ns_q, cnt_nx[ACTION_W-1:0]} :
                    (cnt_q == PEN) ? {s_q, a_q} : rd_addr_q;
      end
      DRAIN: state_d = CALC;
      CALC: begin
        state_d   = WRITE;
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
        wr_addr_d = {s_q, a_q};
        wr_data_d = q_clamped;
        best_d    = run_best_q;
        max_out_d = mq[DATA_WIDTH-1:0];
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Read data trails its address by one cycle; the last slot of each burst is Q(s,a).
    if (rd_vld_q) begin
      if (rd_idx_q == LAST) qsa_d = bus.i_rd_data;
      else if (bus.i_rd_data > run_max_q) begin
        run_max_d  = bus.i_rd_data;
        run_best_d = rd_idx_q[ACTION_W-1:0];
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      a_q        <= '0;
      r_q        <= '0;
      ns_q       <= '0;
      term_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      run_max_q  <= '0;
      run_best_q <= '0;
      qsa_q      <= '0;
      ready_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      best_q     <= '0;
      max_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      a_q        <= a_d;
      r_q        <= r_d;
      ns_q       <= ns_d;
      term_q     <= term_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      run_max_q  <= run_max_d;
      run_best_q <= run_best_d;
      qsa_q      <= qsa_d;
      ready_q    <= ready_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      best_q     <= best_d;
      max_out_q  <= max_out_d;
    end
  end
  assign bus.o_ready       = ready_q;
  assign bus.o_rd_en       = rd_en_q;
  assign bus.o_rd_addr     = rd_addr_q;
  assign bus.o_wr_en       = wr_en_q;
  assign bus.o_wr_addr     = wr_addr_q;
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_done        = done_q;
  assign bus.o_best_action = best_q;
  assign bus.o_max_q       = max_out_q;
endmodule

// File: tb/tb_qtable_update_engine.sv
// tb_qtable_update_engine: directed vectors against a behavioural Q-table BRAM
module tb_qtable_update_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  qtable_update_engine_if bus ();
  qtable_update_engine dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  logic [7:0] mem [256];
  logic       clr, pre_we;
  logic [7:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.o_wr_en) mem[bus.o_wr_addr] <= bus.o_wr_data;
    bus.i_rd_data <= bus.o_rd_en ? mem[bus.o_rd_addr] : 'x;
  end
  int rd_total = 0, wr_total = 0, overlap = 0;
  logic [7:0] rd_hist [512];
  always @(negedge clk) begin
    if (bus.o_rd_en) begin
      rd_hist[rd_total[8:0]] <= bus.o_rd_addr;
      rd_total <= rd_total + 1;
    end
    if (bus.o_wr_en) wr_total <= wr_total + 1;
    if (bus.o_rd_en && bus.o_wr_en) overlap <= overlap + 1;
  end
  int checks = 0, errors = 0;
  int lat, rd_base, wr_snap;
  logic [7:0] g_waddr, g_wdata, g_maxq;
  logic [1:0] g_best;
  logic       g_done;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic preload(input logic [7:0] addr, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask
  // Returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic [5:0] s, input logic [1:0] a, input logic [7:0] r,
                       input logic [5:0] ns, input logic t);
    int n = 0;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_state = s; bus.i_action = a;
    bus.i_reward = r; bus.i_next_state = ns; bus.i_terminal = t;
    while (!bus.o_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    rd_base = rd_total;
  endtask
  task automatic scramble(input logic hold);
    bus.i_valid = hold;
    bus.i_state = 6'($urandom); bus.i_action = 2'($urandom);
    bus.i_reward = 8'($urandom); bus.i_next_state = 6'($urandom);
    bus.i_terminal = 1'($urandom);
  endtask
  task automatic finish_update();
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.o_wr_en) begin
        lat = n; g_waddr = bus.o_wr_addr; g_wdata = bus.o_wr_data;
        g_done = bus.o_done; g_best = bus.o_best_action; g_maxq = bus.o_max_q;
        break;
      end
      @(negedge clk);
    end
  endtask
  logic [7:0] exp_rd [5];
  initial begin
    rst = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.i_valid = 1'b0; bus.i_state = '0; bus.i_action = '0; bus.i_reward = '0;
    bus.i_next_state = '0; bus.i_terminal = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_rd_en", bus.o_rd_en, 0);
    chk("rst_wr_en", bus.o_wr_en, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_rd_addr", bus.o_rd_addr, 0);
    chk("rst_wr_addr", bus.o_wr_addr, 0);
    chk("rst_wr_data", bus.o_wr_data, 0);
    chk("rst_best", bus.o_best_action, 0);
    chk("rst_maxq", bus.o_max_q, 0);
    rst = 1'b0; clr = 1'b0;
    // Zero table, r=0: read order and latency
    issue(6'd5, 2'd2, 8'd0, 6'd9, 1'b0);
    scramble(1'b0);
    finish_update();
    exp_rd = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h16};
    for (int i = 0; i < 5; i++) chk("rd_addr_seq", rd_hist[rd_base + i], exp_rd[i]);
    chk("rd_count", rd_total - rd_base, 5);
    chk("t1_latency", lat, 8);
    chk("t1_done", g_done, 1);
    chk("t1_waddr", g_waddr, 8'h16);
    chk("t1_wdata", g_wdata, 0);
    @(negedge clk);
    chk("t1_ready_back", bus.o_ready, 1);
    chk("t1_done_pulse", bus.o_done, 0);
    // Q(9,.)={0,64,10,64}, r=16 -> 36, tie resolves to action 1
    preload(8'h24, 8'd0); preload(8'h25, 8'd64); preload(8'h26, 8'd10); preload(8'h27, 8'd64);
    issue(6'd5, 2'd2, 8'd16, 6'd9, 1'b0);
    scramble(1'b0);
    finish_update();
    chk("t2_latency", lat, 8);
    chk("t2_wdata", g_wdata, 36);
    chk("t2_best", g_best, 1);
    chk("t2_maxq", g_maxq, 64);
    @(negedge clk);
    chk("t2_mem", mem[8'h16], 36);
    chk("t2_best_held", bus.o_best_action, 1);
    // Saturation: Q(s,a)=250, r=255, max 255 -> clamp 255
    preload(8'h07, 8'd250);
    for (int i = 0; i < 4; i++) preload(8'(8'h08 + i), 8'd255);
    issue(6'd1, 2'd3, 8'd255, 6'd2, 1'b0);
    scramble(1'b0);
    finish_update();
    chk("sat_wdata", g_wdata, 255);
    chk("sat_waddr", g_waddr, 8'h07);
    chk("sat_maxq", g_maxq, 255);
    chk("sat_best", g_best, 0);
    // Terminal: Q(s,a)=100, r=0 -> 50, max forced to 0
    preload(8'h0D, 8'd100);
    preload(8'h10, 8'd5); preload(8'h11, 8'd200); preload(8'h12, 8'd7); preload(8'h13, 8'd9);
    issue(6'd3, 2'd1, 8'd0, 6'd4, 1'b1);
    scramble(1'b0);
    finish_update();
    chk("term_wdata", g_wdata, 50);
    chk("term_maxq", g_maxq, 0);
    // Back-to-back same address: 0 -> 8 -> 12
    issue(6'd10, 2'd0, 8'd16, 6'd20, 1'b0);
    scramble(1'b0);
    finish_update();
    chk("b2b_first", g_wdata, 8);
    issue(6'd10, 2'd0, 8'd16, 6'd20, 1'b0);
    scramble(1'b0);
    finish_update();
    chk("b2b_second", g_wdata, 12);
    chk("b2b_waddr", g_waddr, 8'h28);
    // Reset three cycles after accept aborts the update
    preload(8'h3F, 8'd77); preload(8'h01, 8'd99);
    wr_snap = wr_total;
    issue(6'd15, 2'd3, 8'd200, 6'd0, 1'b0);
    scramble(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_rd_en", bus.o_rd_en, 0);
    chk("abort_wr_en", bus.o_wr_en, 0);
    chk("abort_maxq", bus.o_max_q, 0);
    chk("abort_best", bus.o_best_action, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_write", wr_total - wr_snap, 0);
    chk("abort_mem", mem[8'h3F], 77);
    // Valid held through busy with changed inputs: second sample taken as soon as ready returns
    issue(6'd6, 2'd1, 8'd32, 6'd7, 1'b0);
    bus.i_state = 6'd8; bus.i_action = 2'd2; bus.i_reward = 8'd64;
    bus.i_next_state = 6'd7; bus.i_terminal = 1'b0;
    finish_update();
    chk("hs_a_latency", lat, 8);
    chk("hs_a_waddr", g_waddr, 8'h19);
    chk("hs_a_wdata", g_wdata, 16);
    @(negedge clk);
    chk("hs_ready_back", bus.o_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("hs_b_accepted", bus.o_ready, 0);
    scramble(1'b0);
    finish_update();
    chk("hs_b_latency", lat, 8);
    chk("hs_b_waddr", g_waddr, 8'h22);
    chk("hs_b_wdata", g_wdata, 32);
    @(negedge clk);
    chk("no_rd_wr_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
